// File: rtl/lcd_line_writer.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_line_writer
//  Description : HD44780-style character-LCD driver. After power-up it
//                initialises the display, then rewrites positions 0..5 of
//                line 1 with char1..char6 every time the presented text
//                differs from the text last written. Each byte is paced by
//                a SETUP / PULSE / HOLD / WAIT sub-sequence driven by a
//                single down-counter.
//  Ports       : clk          - system clock, rising edge
//                rst          - asynchronous active-high reset
//                char1..char6 - character codes, bit 8 = RS, bits 7:0 = byte
//                lcd_rs       - LCD register select
//                lcd_rw       - LCD read/write, constant 0 (write only)
//                lcd_en       - LCD enable strobe
//                lcd_data     - LCD data bus
//                busy         - high whenever the controller is not idle
//                init_done    - set once the init sequence has completed
//                refresh_done - one-cycle pulse in the final wait cycle of
//                               the sixth character
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_line_writer #(
    parameter int T_AS    = 4,
    parameter int T_PW    = 25,
    parameter int T_CMD   = 2500,
    parameter int T_CLR   = 100000,
    parameter int T_PWRUP = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] char1,
    input  logic [8:0] char2,
    input  logic [8:0] char3,
    input  logic [8:0] char4,
    input  logic [8:0] char5,
    input  logic [8:0] char6,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data,
    output logic       busy,
    output logic       init_done,
    output logic       refresh_done
);

    // Counter must hold the largest reload value (parameter - 1).
    localparam int c_MAX_A = (T_AS > T_PW) ? T_AS : T_PW;
    localparam int c_MAX_B = (T_CMD > T_CLR) ? T_CMD : T_CLR;
    localparam int c_MAX_C = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_MAX_T = (c_MAX_C > T_PWRUP) ? c_MAX_C : T_PWRUP;
    localparam int c_CNT_W = $clog2(c_MAX_T + 1);

    localparam logic [c_CNT_W-1:0] c_LD_AS    = c_CNT_W'(T_AS - 1);
    localparam logic [c_CNT_W-1:0] c_LD_PW    = c_CNT_W'(T_PW - 1);
    localparam logic [c_CNT_W-1:0] c_LD_CMD   = c_CNT_W'(T_CMD - 1);
    localparam logic [c_CNT_W-1:0] c_LD_CLR   = c_CNT_W'(T_CLR - 1);
    localparam logic [c_CNT_W-1:0] c_LD_PWRUP = c_CNT_W'(T_PWRUP - 1);

    localparam logic [7:0] c_CMD_SET_ADDR = 8'h80;
    localparam logic [7:0] c_CMD_CLEAR    = 8'h01;

    typedef enum logic [2:0] {
        S_PWRUP = 3'd0,
        S_INIT  = 3'd1,
        S_IDLE  = 3'd2,
        S_ADDR  = 3'd3,
        S_CHAR  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        P_SETUP = 2'd0,
        P_PULSE = 2'd1,
        P_HOLD  = 2'd2,
        P_WAIT  = 2'd3
    } phase_t;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h38;   // 8-bit bus, 2 lines, 5x8 font
            3'd1:    b = 8'h0C;   // display on, cursor off
            3'd2:    b = 8'h06;   // auto-increment, no shift
            default: b = c_CMD_CLEAR;
        endcase
        return b;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t               r_state;
    phase_t               r_phase;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2:0]           r_idx;
    logic                 r_rs;
    logic [7:0]           r_data;
    logic                 r_en;
    logic                 r_init_done;
    logic                 r_pending;
    logic [8:0]           r_snap [6];

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t               w_state_nxt;
    phase_t               w_phase_nxt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [2:0]           w_idx_nxt;
    logic                 w_rs_nxt;
    logic [7:0]           w_data_nxt;
    logic                 w_en_nxt;
    logic                 w_init_done_nxt;
    logic                 w_pending_nxt;
    logic [8:0]           w_snap_nxt [6];
    logic                 w_refresh_done;

    // Request to start a new byte (enter SETUP with these RS/data values).
    logic                 w_load;
    logic                 w_load_rs;
    logic [7:0]           w_load_data;

    logic [8:0]           w_chars [6];
    logic                 w_changed;
    logic                 w_is_clear;
    logic [2:0]           w_idx_inc;

    assign w_chars[0] = char1;
    assign w_chars[1] = char2;
    assign w_chars[2] = char3;
    assign w_chars[3] = char4;
    assign w_chars[4] = char5;
    assign w_chars[5] = char6;

    assign w_idx_inc  = r_idx + 3'd1;

    // The clear command needs the long wait; judged on the byte on the bus.
    assign w_is_clear = (r_rs == 1'b0) && (r_data == c_CMD_CLEAR);

    always_comb begin
        w_changed = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (w_chars[i] != r_snap[i]) begin
                w_changed = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_phase_nxt     = r_phase;
        w_cnt_nxt       = r_cnt;
        w_idx_nxt       = r_idx;
        w_rs_nxt        = r_rs;
        w_data_nxt      = r_data;
        w_en_nxt        = r_en;
        w_init_done_nxt = r_init_done;
        w_pending_nxt   = r_pending;
        w_refresh_done  = 1'b0;
        w_load          = 1'b0;
        w_load_rs       = 1'b0;
        w_load_data     = 8'h00;
        for (int i = 0; i < 6; i++) begin
            w_snap_nxt[i] = r_snap[i];
        end

        case (r_state)
            S_PWRUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_INIT;
                    w_idx_nxt   = 3'd0;
                    w_load      = 1'b1;
                    w_load_data = init_byte(3'd0);
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end

            S_IDLE: begin
                if (r_pending || w_changed) begin
                    for (int i = 0; i < 6; i++) begin
                        w_snap_nxt[i] = w_chars[i];
                    end
                    w_pending_nxt = 1'b0;
                    w_state_nxt   = S_ADDR;
                    w_load        = 1'b1;
                    w_load_data   = c_CMD_SET_ADDR;
                end
            end

            // S_INIT, S_ADDR, S_CHAR all run the byte sub-sequence.
            default: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    case (r_phase)
                        P_SETUP: begin
                            w_phase_nxt = P_PULSE;
                            w_en_nxt    = 1'b1;
                            w_cnt_nxt   = c_LD_PW;
                        end
                        P_PULSE: begin
                            w_phase_nxt = P_HOLD;
                            w_en_nxt    = 1'b0;
                            w_cnt_nxt   = c_LD_AS;
                        end
                        P_HOLD: begin
                            w_phase_nxt = P_WAIT;
                            w_cnt_nxt   = w_is_clear ? c_LD_CLR : c_LD_CMD;
                        end
                        default: begin
                            // Byte finished: choose the next byte or stop.
                            case (r_state)
                                S_INIT: begin
                                    if (r_idx == 3'd3) begin
                                        w_init_done_nxt = 1'b1;
                                        w_pending_nxt   = 1'b1;
                                        w_state_nxt     = S_IDLE;
                                    end else begin
                                        w_idx_nxt   = w_idx_inc;
                                        w_load      = 1'b1;
                                        w_load_data = init_byte(w_idx_inc);
                                    end
                                end
                                S_ADDR: begin
                                    w_state_nxt = S_CHAR;
                                    w_idx_nxt   = 3'd0;
                                    w_load      = 1'b1;
                                    w_load_rs   = r_snap[0][8];
                                    w_load_data = r_snap[0][7:0];
                                end
                                default: begin
                                    if (r_idx == 3'd5) begin
                                        w_refresh_done = 1'b1;
                                        w_state_nxt    = S_IDLE;
                                    end else begin
                                        w_idx_nxt   = w_idx_inc;
                                        w_load      = 1'b1;
                                        w_load_rs   = r_snap[w_idx_inc][8];
                                        w_load_data = r_snap[w_idx_inc][7:0];
                                    end
                                end
                            endcase
                        end
                    endcase
                end
            end
        endcase

        // RS/data only ever change here, on SETUP entry.
        if (w_load) begin
            w_rs_nxt    = w_load_rs;
            w_data_nxt  = w_load_data;
            w_en_nxt    = 1'b0;
            w_phase_nxt = P_SETUP;
            w_cnt_nxt   = c_LD_AS;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_PWRUP;
            r_phase     <= P_SETUP;
            r_cnt       <= c_LD_PWRUP;
            r_idx       <= 3'd0;
            r_rs        <= 1'b0;
            r_data      <= 8'h00;
            r_en        <= 1'b0;
            r_init_done <= 1'b0;
            r_pending   <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                r_snap[i] <= 9'd0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_rs        <= w_rs_nxt;
            r_data      <= w_data_nxt;
            r_en        <= w_en_nxt;
            r_init_done <= w_init_done_nxt;
            r_pending   <= w_pending_nxt;
            for (int i = 0; i < 6; i++) begin
                r_snap[i] <= w_snap_nxt[i];
            end
        end
    end

    assign lcd_rs       = r_rs;
    assign lcd_rw       = 1'b0;
    assign lcd_en       = r_en;
    assign lcd_data     = r_data;
    assign busy         = (r_state != S_IDLE);
    assign init_done    = r_init_done;
    assign refresh_done = w_refresh_done;

endmodule
`default_nettype wire
